// File: rtl/regs_wb_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// lc3b_pkg
//   Shared LC-3b types and constants used by the register-file write-back
//   arbiter, its scoreboard and anything else that talks to `regs`.
//
//   REG_W      register / data width
//   REG_AW     register index width
//   NREG       number of architectural registers
//   reg_idx_t  register index
//   word_t     register data word
//   wb_gnt_t   identity of a write-back requester (A = ALU/shift, B = load)
//   wb_req_t   destination index + data carried by one write-back
// ---------------------------------------------------------------------------
package lc3b_pkg;

   localparam int REG_W  = 16;
   localparam int REG_AW = 3;
   localparam int NREG   = 8;

   typedef logic [REG_AW-1:0] reg_idx_t;
   typedef logic [REG_W-1:0]  word_t;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } wb_gnt_t;

   typedef struct packed {
      reg_idx_t dr;
      word_t    data;
   } wb_req_t;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regs_wb_arbiter_if
//   Bundles every non-clock signal of the write-back arbiter.
//
//   a_valid/a_dr/a_data/a_ready   requester A (ALU/shift) handshake
//   b_valid/b_dr/b_data/b_ready   requester B (memory load) handshake
//   iss_valid/iss_dr/iss_ready    issue-stage destination reservation
//   sr1/sr2 -> sr1_busy/sr2_busy  source-operand hazard lookups
//   busy                          full per-register scoreboard
//   ld_reg/dr/data                registered write port toward `regs`
//
//   modport slave  : the arbiter itself
//   modport master : requesters, issue logic and the register file
// ---------------------------------------------------------------------------
interface regs_wb_arbiter_if
   import lc3b_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int NREG   = lc3b_pkg::NREG,
   parameter int AW     = REG_AW
);

   logic              a_valid;
   logic [AW-1:0]     a_dr;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;

   logic              b_valid;
   logic [AW-1:0]     b_dr;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;

   logic              iss_valid;
   logic [AW-1:0]     iss_dr;
   logic              iss_ready;

   logic [AW-1:0]     sr1;
   logic [AW-1:0]     sr2;
   logic              sr1_busy;
   logic              sr2_busy;
   logic [NREG-1:0]   busy;

   logic              ld_reg;
   logic [AW-1:0]     dr;
   logic [DATA_W-1:0] data;

   modport slave (
      input  a_valid, a_dr, a_data,
      output a_ready,
      input  b_valid, b_dr, b_data,
      output b_ready,
      input  iss_valid, iss_dr,
      output iss_ready,
      input  sr1, sr2,
      output sr1_busy, sr2_busy, busy,
      output ld_reg, dr, data
   );

   modport master (
      output a_valid, a_dr, a_data,
      input  a_ready,
      output b_valid, b_dr, b_data,
      input  b_ready,
      output iss_valid, iss_dr,
      input  iss_ready,
      output sr1, sr2,
      input  sr1_busy, sr2_busy, busy,
      input  ld_reg, dr, data
   );

endinterface

// File: rtl/regs_wb_arbiter_scoreboard.sv
// ---------------------------------------------------------------------------
// regs_scoreboard
//   Per-register "write pending" bits for the LC-3b register file.
//
//   clk, rst          clock, asynchronous active-low reset
//   iss_valid/iss_dr  issue stage asks to reserve a destination
//   iss_ready         reservation accepted this cycle
//   ld_reg/wr_dr      registered write currently going into `regs`
//   sr1/sr2           source indices to look up
//   sr1_busy/sr2_busy source has a pending write (registered state only)
//   busy              full scoreboard vector
// ---------------------------------------------------------------------------
module regs_scoreboard #(
   parameter int NREG = 8,
   parameter int AW   = 3
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [AW-1:0]   iss_dr,
   output logic            iss_ready,
   input  logic            ld_reg,
   input  logic [AW-1:0]   wr_dr,
   input  logic [AW-1:0]   sr1,
   input  logic [AW-1:0]   sr2,
   output logic            sr1_busy,
   output logic            sr2_busy,
   output logic [NREG-1:0] busy
);

   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;
   logic            iss_fire;

   // A destination whose last pending write is retiring this very cycle can
   // be re-reserved now: the clear and the new set meet at the same edge.
   always_comb begin
      iss_ready = 1'b0;
      if (rst) begin
         iss_ready = !busy_q[iss_dr] || (ld_reg && (wr_dr == iss_dr));
      end
   end

   assign iss_fire = iss_valid && iss_ready;

   // NOTE: every combinational output gets a default before any branch, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      busy_d = busy_q;
      if (ld_reg) begin
         busy_d[wr_dr] = 1'b0;
      end
      // Applied after the clear so a same-index set wins.
      if (iss_fire) begin
         busy_d[iss_dr] = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process ordering.
   // The busy vector is only NREG flops of control state, so it is reset
   // like any other control register rather than treated as a memory.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Hazard lookups look at registered state only; a write being granted
   // this cycle does not hide its destination yet.
   assign sr1_busy = busy_q[sr1];
   assign sr2_busy = busy_q[sr2];
   assign busy     = busy_q;

endmodule

// File: rtl/regs_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regs_wb_arbiter
//   Shares the single write port of the LC-3b register file between the
//   ALU/shift path (A) and the memory-load path (B). Round-robin grant,
//   valid/ready handshake, one registered write stage toward `regs`, plus
//   a busy scoreboard so issue logic can stall on pending destinations.
//
//   clk  sole clock, rising edge
//   rst  asynchronous, active-low reset
//   bus  regs_wb_arbiter_if.slave: requester handshakes, issue reservation,
//        source hazard lookups, busy vector and the ld_reg/dr/data port
// ---------------------------------------------------------------------------
module regs_wb_arbiter
   import lc3b_pkg::*;
#(
   parameter int DATA_W = REG_W,
   parameter int NREG   = lc3b_pkg::NREG,
   parameter int AW     = REG_AW
) (
   input  logic              clk,
   input  logic              rst,
   regs_wb_arbiter_if.slave  bus
);

   wb_gnt_t           last_q;
   wb_gnt_t           last_d;
   logic              gnt_a;
   logic              gnt_b;

   logic [AW-1:0]     sel_dr;
   logic [DATA_W-1:0] sel_data;

   logic              ld_q;
   logic [AW-1:0]     dr_q;
   logic [DATA_W-1:0] data_q;

   // ---------------------------------------------------------------
   // Round-robin state: who won the most recent grant.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // B "went last" out of reset so A wins the first contention.
         last_q <= GNT_B;
      end else begin
         last_q <= last_d;
      end
   end

   // Grant is purely combinational; `regs` always accepts, so there is no
   // downstream backpressure to fold in. During reset nobody is granted.
   always_comb begin
      gnt_a  = 1'b0;
      gnt_b  = 1'b0;
      last_d = last_q;
      if (rst) begin
         if (bus.a_valid && (!bus.b_valid || (last_q == GNT_B))) begin
            gnt_a = 1'b1;
         end else if (bus.b_valid) begin
            gnt_b = 1'b1;
         end
      end
      if (gnt_a) begin
         last_d = GNT_A;
      end else if (gnt_b) begin
         last_d = GNT_B;
      end
   end

   assign bus.a_ready = gnt_a;
   assign bus.b_ready = gnt_b;

   // Write-stage input mux; only meaningful on a grant cycle.
   always_comb begin
      sel_dr   = bus.a_dr;
      sel_data = bus.a_data;
      if (gnt_b) begin
         sel_dr   = bus.b_dr;
         sel_data = bus.b_data;
      end
   end

   // ---------------------------------------------------------------
   // Registered write stage toward `regs`. Index/data hold when idle so
   // the port does not toggle needlessly; reset drops any pending write.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ld_q   <= 1'b0;
         dr_q   <= '0;
         data_q <= '0;
      end else begin
         ld_q <= gnt_a || gnt_b;
         if (gnt_a || gnt_b) begin
            dr_q   <= sel_dr;
            data_q <= sel_data;
         end
      end
   end

   assign bus.ld_reg = ld_q;
   assign bus.dr     = dr_q;
   assign bus.data   = data_q;

   // ---------------------------------------------------------------
   // Busy scoreboard, cleared by the write stage as it retires.
   // ---------------------------------------------------------------
   regs_scoreboard #(
      .NREG (NREG),
      .AW   (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (bus.iss_valid),
      .iss_dr    (bus.iss_dr),
      .iss_ready (bus.iss_ready),
      .ld_reg    (ld_q),
      .wr_dr     (dr_q),
      .sr1       (bus.sr1),
      .sr2       (bus.sr2),
      .sr1_busy  (bus.sr1_busy),
      .sr2_busy  (bus.sr2_busy),
      .busy      (bus.busy)
   );

endmodule

// File: doc/regs_wb_arbiter.md
# regs_wb_arbiter

Write-back arbiter and scoreboard for the LC-3b register file (`regs`). It shares the register file's single write port between two write-back requesters: A is the ALU/shift path and B is the memory-load path. Arbitration is round-robin with a valid/ready handshake. The block drives `ld_reg`/`dr`/`data` to `regs` from a registered stage. It also keeps a per-register busy scoreboard, so the issue logic can stall on pending destinations and on source-operand hazards.

## Interface
Parameters:
- `DATA_W`, 16, register/data width
- `NREG`, 8, number of architectural registers
- `AW`, 3, register index width, equal to clog2(NREG)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `a_valid`  in  1  requester A has a write
- `a_dr`  in  AW  A destination index
- `a_data`  in  DATA_W  A write data
- `a_ready`  out  1  A granted this cycle
- `b_valid`, `b_dr`, `b_data`, `b_ready`  same as A, for requester B
- `iss_valid`  in  1  issue stage reserves a destination
- `iss_dr`  in  AW  destination to reserve
- `iss_ready`  out  1  reservation accepted this cycle
- `sr1`, `sr2`  in  AW  source indices to check
- `sr1_busy`, `sr2_busy`  out  1  source has a pending write
- `busy`  out  NREG  full scoreboard vector
- `ld_reg`  out  1  write strobe to `regs`
- `dr`  out  AW  write index to `regs`
- `data`  out  DATA_W  write data to `regs`

## Operation
- Grant is combinational. A transfer occurs on a cycle where `x_valid && x_ready`.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not granted most recently is granted. The state is `last_grant`, values A or B.
  - `last_grant` updates only on a grant cycle.
  - `a_ready` and `b_ready` are never both high.
  - Ready does not depend on any downstream backpressure, because `regs` always accepts.
- Write stage: on the edge ending a grant cycle, `ld_reg<=1` and `dr`/`data<=` the granted requester's index/data. With no grant, `ld_reg<=0` and `dr`/`data` hold their values.
- Scoreboard, `busy[NREG]`:
  - `iss_ready = !busy[iss_dr] || (ld_reg && dr==iss_dr)`.
  - On `iss_valid && iss_ready`, `busy[iss_dr]` is set at the edge.
  - On `ld_reg`, `busy[dr]` is cleared at the edge.
  - Set and clear of the same index at the same edge: set wins, and the bit stays 1.
  - Clearing a bit that is already 0 is a no-op. Untracked writes are legal.
- `sr1_busy = busy[sr1]` and `sr2_busy = busy[sr2]`. These read the registered state only, with no bypass from the current grant.
- Requesters must hold valid, dr and data stable until ready. The block does not check this.

## Timing
- Reset values while `rst` is low, asynchronous: `ld_reg=0`, `dr=0`, `data=0`, `busy=0`, `last_grant=B` (so A wins the first contention). `a_ready`, `b_ready` and `iss_ready` are forced 0.
- Latency:
  - Grant in cycle N gives `ld_reg=1` in cycle N+1.
  - `regs` captures the write at the end of N+1, and `busy[dr]` clears at the same edge.
  - In N+2 the register holds the new value and its busy bit reads 0.
- Throughput: one write per cycle. Under continuous contention A and B alternate.
- Back-to-back grants to the same `dr` are legal; the later write wins in `regs`.
- Reset asserted mid-operation discards any pending write stage. `ld_reg` drops immediately (asynchronous) and no write reaches `regs`.

## Structure
- Shared package `lc3b_pkg`: `REG_W=16`, `REG_AW=3`, `NREG=8`, `typedef reg_idx_t` (AW bits), `typedef word_t` (16 bits), `typedef enum {GNT_A, GNT_B} wb_gnt_t`.
- Sub-module `regs_scoreboard` holds the busy vector, set/clear precedence, `iss_ready` and the source lookups.
- The top level holds the round-robin arbiter and the write-stage register.

## Test plan
- Reset, then only A valid with dr=3, data=16'h1234: `a_ready=1` in cycle N; `ld_reg=1`, `dr=3`, `data=16'h1234` in N+1; `ld_reg=0` in N+2.
- A and B both valid continuously for 4 cycles: grants go A,B,A,B; `ld_reg` stays high for 4 consecutive cycles with the matching dr/data.
- Issue dr=5: `busy=8'h20` and `sr1=5` gives `sr1_busy=1`. Re-issue dr=5 gives `iss_ready=0`. B writes dr=5: busy clears 2 cycles after the grant.
- Issue dr=2 in the same cycle that `ld_reg=1`, `dr=2`: `iss_ready=1`, and `busy[2]` stays 1 afterwards (set wins).
- Assert `rst` low in the cycle after an A grant: `ld_reg` goes 0 immediately, busy reads 0, and the first contention after release grants A.
